alb_operand_rf: RTL and testbench

- Operand-source and writeback stage feeding the 4-bit arithmetic-logic block: 16-entry register file plus Q register, flag/status register.
- Drives R/S operands combinationally during the issue cycle.
- ALU registers its inputs, so the result appears one cycle later; this block pipelines the destination info to match and writes F_ALB and flags back.
- Forwards the in-flight result to younger reads.

---
 rtl/alb_pkg.sv | 40 ++++
 rtl/alb_rf_mem.sv | 37 +++
 rtl/alb_operand_rf.sv | 136 +++++++++++++
 tb/tb_alb_operand_rf.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alb_pkg.sv
// Purpose : shared constants for the ALB operand/writeback stage.
// Latency : n/a (package only).
// Backpressure: n/a.
package alb_pkg;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  // Operand source select, named as {R,S}: A/B = RAM ports, Q, D = d_in, Z = 0
  localparam logic [2:0] SRC_AQ = 3'b000;
  localparam logic [2:0] SRC_AB = 3'b001;
  localparam logic [2:0] SRC_ZQ = 3'b010;
  localparam logic [2:0] SRC_ZB = 3'b011;
  localparam logic [2:0] SRC_ZA = 3'b100;
  localparam logic [2:0] SRC_DA = 3'b101;
  localparam logic [2:0] SRC_DQ = 3'b110;
  localparam logic [2:0] SRC_DZ = 3'b111;

  // Destination select; bit 0 = RAM[b_addr], bit 1 = Q
  localparam logic [1:0] DST_NONE = 2'b00;
  localparam logic [1:0] DST_RAM  = 2'b01;
  localparam logic [1:0] DST_Q    = 2'b10;
  localparam logic [1:0] DST_RAMQ = 2'b11;

  // Bit positions inside status = {C,V,N,Z}
  localparam int ST_C = 3;
  localparam int ST_V = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  // Destination info carried from issue to writeback
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              ram;
    logic              q;
    logic              flag;
  } wb_t;

endpackage

// File: rtl/alb_rf_mem.sv
// Purpose : D x W register file, two async read ports, one sync write port.
// Latency : reads combinational; write visible after the clock edge.
// Backpressure: none; write accepted every cycle we=1.
// Ports   : clk, reset (async, clears all entries), a_addr/a_data, b_addr/b_data
//           read ports, we/wr_addr/wr_data write port.
module alb_rf_mem
  import alb_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int D  = DEPTH,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] a_addr,
  output logic [W-1:0]  a_data,
  input  logic [AW-1:0] b_addr,
  output logic [W-1:0]  b_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign a_data = mem[a_addr];
  assign b_data = mem[b_addr];

endmodule

// File: rtl/alb_operand_rf.sv
// Purpose : operand source mux + RAM/Q/status writeback for the 4-bit ALB.
// Latency : operands combinational in the issue cycle; result written on the edge ending issue+1.
// Backpressure: none; one op per cycle, hazard flags stale reads when bypass is not built.
// Ports   : clk, reset (async active-high); issue/a_addr/b_addr/src/d_in/dest/flag_we
//           describe the op; f_alb/co/vo/no/zo are the ALU result one cycle later;
//           r_out/s_out operands, q_out, status {C,V,N,Z}, wb_busy, hazard.
// Build   : define ALB_RF_BYPASS_EN to forward the in-flight result to reads.
module alb_operand_rf
  import alb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [2:0]        src,
  input  logic [WIDTH-1:0]  d_in,
  input  logic [1:0]        dest,
  input  logic              flag_we,
  input  logic [WIDTH-1:0]  f_alb,
  input  logic              co,
  input  logic              vo,
  input  logic              no,
  input  logic              zo,
  output logic [WIDTH-1:0]  r_out,
  output logic [WIDTH-1:0]  s_out,
  output logic [WIDTH-1:0]  q_out,
  output logic [3:0]        status,
  output logic              wb_busy,
  output logic              hazard
);

  wb_t              wb;
  logic [WIDTH-1:0] q_reg;
  logic [3:0]       st_reg;
  logic [WIDTH-1:0] mem_a, mem_b;
  logic [WIDTH-1:0] rd_a, rd_b, rd_q;
  logic             capture;

  alb_rf_mem #(.W(WIDTH), .D(DEPTH), .AW(ADDR_W)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .a_addr  (a_addr),
    .a_data  (mem_a),
    .b_addr  (b_addr),
    .b_data  (mem_b),
    .we      (wb_busy & wb.ram),
    .wr_addr (wb.addr),
    .wr_data (f_alb)
  );

`ifdef ALB_RF_BYPASS_EN
  // In-flight result replaces storage for any matching read; A and B forward independently
  always_comb begin
    rd_a = mem_a;
    rd_b = mem_b;
    rd_q = q_reg;
    if (wb_busy && wb.ram && (a_addr == wb.addr)) rd_a = f_alb;
    if (wb_busy && wb.ram && (b_addr == wb.addr)) rd_b = f_alb;
    if (wb_busy && wb.q) rd_q = f_alb;
  end

  assign hazard = 1'b0;
`else
  logic use_a, use_b, use_q;

  assign rd_a = mem_a;
  assign rd_b = mem_b;
  assign rd_q = q_reg;

  // Only reads that the selected source actually consumes count as conflicts
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    use_q = 1'b0;
    case (src)
      SRC_AQ: begin use_a = 1'b1; use_q = 1'b1; end
      SRC_AB: begin use_a = 1'b1; use_b = 1'b1; end
      SRC_ZQ: use_q = 1'b1;
      SRC_ZB: use_b = 1'b1;
      SRC_ZA: use_a = 1'b1;
      SRC_DA: use_a = 1'b1;
      SRC_DQ: use_q = 1'b1;
      default: ;
    endcase
  end

  assign hazard = issue & wb_busy &
                  ((use_a & wb.ram & (a_addr == wb.addr)) |
                   (use_b & wb.ram & (b_addr == wb.addr)) |
                   (use_q & wb.q));
`endif

  always_comb begin
    r_out = '0;
    s_out = '0;
    if (issue) begin
      case (src)
        SRC_AQ: begin r_out = rd_a; s_out = rd_q; end
        SRC_AB: begin r_out = rd_a; s_out = rd_b; end
        SRC_ZQ: s_out = rd_q;
        SRC_ZB: s_out = rd_b;
        SRC_ZA: s_out = rd_a;
        SRC_DA: begin r_out = d_in; s_out = rd_a; end
        SRC_DQ: begin r_out = d_in; s_out = rd_q; end
        default: r_out = d_in;
      endcase
    end
  end

  assign capture = issue & ((dest != DST_NONE) | flag_we);

  // Writeback of the previous op and capture of the new one share the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb      <= '0;
      wb_busy <= 1'b0;
      q_reg   <= '0;
      st_reg  <= '0;
    end else begin
      if (wb_busy && wb.q)    q_reg  <= f_alb;
      if (wb_busy && wb.flag) st_reg <= {co, vo, no, zo};
      wb_busy <= capture;
      if (capture) begin
        wb.addr <= b_addr;
        wb.ram  <= dest[0];
        wb.q    <= dest[1];
        wb.flag <= flag_we;
      end
    end
  end

  assign q_out  = q_reg;
  assign status = st_reg;

endmodule

// File: tb/tb_alb_operand_rf.sv
module tb_alb_operand_rf;
  import alb_pkg::*;

`ifdef ALB_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              issue;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [2:0]        src;
  logic [WIDTH-1:0]  d_in;
  logic [1:0]        dest;
  logic              flag_we;
  logic [WIDTH-1:0]  f_alb;
  logic              co, vo, no, zo;
  logic [WIDTH-1:0]  r_out, s_out, q_out;
  logic [3:0]        status;
  logic              wb_busy, hazard;

  alb_operand_rf dut (
    .clk(clk), .reset(reset), .issue(issue), .a_addr(a_addr), .b_addr(b_addr),
    .src(src), .d_in(d_in), .dest(dest), .flag_we(flag_we), .f_alb(f_alb),
    .co(co), .vo(vo), .no(no), .zo(zo), .r_out(r_out), .s_out(s_out),
    .q_out(q_out), .status(status), .wb_busy(wb_busy), .hazard(hazard)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Operand source table: 0 = zero, 1 = A, 2 = B, 3 = Q, 4 = D
  int rsel [8] = '{1, 1, 0, 0, 0, 4, 4, 4};
  int ssel [8] = '{3, 2, 3, 2, 1, 1, 3, 0};

  typedef struct {
    bit v;
    int addr;
    bit ram;
    bit q;
    bit flag;
  } pend_t;

  logic [3:0] m_ram [16];
  logic [3:0] m_q, m_st;
  pend_t      pd;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 4'h0;
    m_q  = 4'h0;
    m_st = 4'h0;
    pd   = '{v: 0, addr: 0, ram: 0, q: 0, flag: 0};
  endtask

  function automatic logic [3:0] pick(int sel, logic [3:0] va, logic [3:0] vb,
                                      logic [3:0] vq, logic [3:0] vd);
    case (sel)
      1: return va;
      2: return vb;
      3: return vq;
      4: return vd;
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_eval(output logic [3:0] er, output logic [3:0] es, output logic eh);
    logic [3:0] va, vb, vq;
    bit ua, ub, uq;
    va = m_ram[a_addr];
    vb = m_ram[b_addr];
    vq = m_q;
    if (BYP && pd.v && pd.ram && int'(a_addr) == pd.addr) va = f_alb;
    if (BYP && pd.v && pd.ram && int'(b_addr) == pd.addr) vb = f_alb;
    if (BYP && pd.v && pd.q) vq = f_alb;
    er = issue ? pick(rsel[src], va, vb, vq, d_in) : 4'h0;
    es = issue ? pick(ssel[src], va, vb, vq, d_in) : 4'h0;
    ua = (rsel[src] == 1) || (ssel[src] == 1);
    ub = (rsel[src] == 2) || (ssel[src] == 2);
    uq = (rsel[src] == 3) || (ssel[src] == 3);
    eh = !BYP && issue && pd.v &&
         ((ua && pd.ram && int'(a_addr) == pd.addr) ||
          (ub && pd.ram && int'(b_addr) == pd.addr) ||
          (uq && pd.q));
  endtask

  task automatic model_edge();
    if (pd.v) begin
      if (pd.ram)  m_ram[pd.addr] = f_alb;
      if (pd.q)    m_q = f_alb;
      if (pd.flag) m_st = {co, vo, no, zo};
    end
    pd.v    = issue && ((dest != 2'b00) || flag_we);
    pd.addr = int'(b_addr);
    pd.ram  = dest[0];
    pd.q    = dest[1];
    pd.flag = flag_we;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       issue;
    logic [2:0] src;
    logic [3:0] a, b, d;
    logic [1:0] dest;
    logic       fwe;
    logic [3:0] f, flg;
    logic [3:0] er, es, eq, est;
    logic       ebusy, ehaz;
  } vec_t;

  function automatic vec_t mk(logic i, logic [2:0] s, logic [3:0] a, logic [3:0] b,
                              logic [3:0] d, logic [1:0] ds, logic fw, logic [3:0] f,
                              logic [3:0] fl, logic [3:0] er, logic [3:0] es,
                              logic [3:0] eq, logic [3:0] est, logic eb, logic eh);
    vec_t v;
    v = '{issue: i, src: s, a: a, b: b, d: d, dest: ds, fwe: fw, f: f, flg: fl,
          er: er, es: es, eq: eq, est: est, ebusy: eb, ehaz: eh};
    return v;
  endfunction

  task automatic drive(logic i, logic [2:0] s, logic [3:0] a, logic [3:0] b, logic [3:0] d,
                       logic [1:0] ds, logic fw, logic [3:0] f, logic [3:0] fl);
    issue = i; src = s; a_addr = a; b_addr = b; d_in = d; dest = ds; flag_we = fw;
    f_alb = f; {co, vo, no, zo} = fl;
  endtask

  vec_t tbl [15];
  logic [3:0] er, es;
  logic       eh;

  initial begin
    // Stale vs forwarded values in rows 5 and 8 depend on the build
    logic [3:0] s5, r8;
    s5 = BYP ? 4'h7 : 4'h0;
    r8 = BYP ? 4'hC : 4'h0;
    //            iss src   a     b     d     dest  fwe f     flg      er    es    eq    est   busy haz
    tbl[0]  = mk(1, 3'd7, 4'h0, 4'h3, 4'h9, 2'd1, 0, 4'h0, 4'b0000, 4'h9, 4'h0, 4'h0, 4'h0, 0, 0);
    tbl[1]  = mk(0, 3'd0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 4'h9, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
    tbl[2]  = mk(1, 3'd3, 4'h0, 4'h3, 4'h0, 2'd0, 0, 4'h0, 4'b0000, 4'h0, 4'h9, 4'h0, 4'h0, 0, 0);
    tbl[3]  = mk(1, 3'd5, 4'h3, 4'h0, 4'h2, 2'd2, 1, 4'h0, 4'b0000, 4'h2, 4'h9, 4'h0, 4'h0, 0, 0);
    tbl[4]  = mk(1, 3'd0, 4'h3, 4'h0, 4'h0, 2'd0, 0, 4'h7, 4'b1101, 4'h9, s5,   4'h0, 4'h0, 1, !BYP);
    tbl[5]  = mk(0, 3'd0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 4'h0, 4'b0000, 4'h0, 4'h0, 4'h7, 4'hD, 0, 0);
    tbl[6]  = mk(1, 3'd7, 4'h0, 4'h5, 4'hC, 2'd1, 0, 4'h0, 4'b0000, 4'hC, 4'h0, 4'h7, 4'hD, 0, 0);
    tbl[7]  = mk(1, 3'd1, 4'h5, 4'h5, 4'h0, 2'd0, 0, 4'hC, 4'b0000, r8,   r8,   4'h7, 4'hD, 1, !BYP);
    tbl[8]  = mk(1, 3'd1, 4'h5, 4'h5, 4'h0, 2'd0, 0, 4'h0, 4'b0000, 4'hC, 4'hC, 4'h7, 4'hD, 0, 0);
    tbl[9]  = mk(1, 3'd7, 4'h0, 4'h0, 4'h0, 2'd0, 1, 4'h0, 4'b0000, 4'h0, 4'h0, 4'h7, 4'hD, 0, 0);
    tbl[10] = mk(0, 3'd0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 4'hF, 4'b0110, 4'h0, 4'h0, 4'h7, 4'hD, 1, 0);
    tbl[11] = mk(1, 3'd1, 4'h3, 4'h5, 4'h0, 2'd0, 0, 4'h0, 4'b0000, 4'h9, 4'hC, 4'h7, 4'h6, 0, 0);
    tbl[12] = mk(1, 3'd7, 4'h0, 4'h5, 4'hA, 2'd1, 0, 4'h0, 4'b0000, 4'hA, 4'h0, 4'h7, 4'h6, 0, 0);
    tbl[13] = mk(0, 3'd0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 4'hA, 4'b0000, 4'h0, 4'h0, 4'h7, 4'h6, 1, 0);
    tbl[14] = mk(1, 3'd1, 4'h5, 4'h0, 4'h0, 2'd0, 0, 4'h0, 4'b0000, 4'hA, 4'h0, 4'h7, 4'h6, 0, 0);

    reset = 1'b1;
    drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 4'h0, 4'h0);
    model_reset();
    #12;
    chk("reset_q", q_out, 4'h0);
    chk("reset_status", status, 4'h0);
    chk("reset_busy", wb_busy, 1'b0);
    chk("reset_r", r_out, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].issue, tbl[i].src, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].dest,
            tbl[i].fwe, tbl[i].f, tbl[i].flg);
      @(negedge clk);
      chk($sformatf("vec%0d_r", i), r_out, tbl[i].er);
      chk($sformatf("vec%0d_s", i), s_out, tbl[i].es);
      chk($sformatf("vec%0d_q", i), q_out, tbl[i].eq);
      chk($sformatf("vec%0d_status", i), status, tbl[i].est);
      chk($sformatf("vec%0d_busy", i), wb_busy, tbl[i].ebusy);
      chk($sformatf("vec%0d_hazard", i), hazard, tbl[i].ehaz);
      model_edge();
      @(posedge clk); #1;
    end

    // Randomized run against the reference model
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom), 4'($urandom), 4'($urandom),
            4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      @(negedge clk);
      model_eval(er, es, eh);
      chk("rnd_r", r_out, er);
      chk("rnd_s", s_out, es);
      chk("rnd_q", q_out, m_q);
      chk("rnd_status", status, m_st);
      chk("rnd_busy", wb_busy, pd.v);
      chk("rnd_hazard", hazard, eh);
      model_edge();
      @(posedge clk); #1;
    end

    // Reset mid-pipeline: a pending RAM/Q/flag write must be dropped
    drive(1, 3'd7, 4'h0, 4'h7, 4'hF, 2'd3, 1, 4'h0, 4'h0);
    @(posedge clk); #1;
    drive(0, 3'd0, 4'h0, 4'h0, 4'h0, 2'd0, 0, 4'hF, 4'hF);
    chk("pre_reset_busy", wb_busy, 1'b1);
    reset = 1'b1;
    #2;
    chk("mid_reset_r", r_out, 4'h0);
    chk("mid_reset_s", s_out, 4'h0);
    chk("mid_reset_q", q_out, 4'h0);
    chk("mid_reset_status", status, 4'h0);
    chk("mid_reset_busy", wb_busy, 1'b0);
    chk("mid_reset_hazard", hazard, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 3'd1, 4'(i), 4'(i), 4'h0, 2'd0, 0, 4'hF, 4'h0);
      @(negedge clk);
      chk($sformatf("clear_ram%0d_r", i), r_out, 4'h0);
      chk($sformatf("clear_ram%0d_s", i), s_out, 4'h0);
      @(posedge clk); #1;
    end
    chk("post_reset_q", q_out, 4'h0);
    chk("post_reset_status", status, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
